// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, state encoding,
// ALU B-select and ALU operation codes, and the packed control word.
package mc_pkg;

  localparam int OPW    = 4;
  localparam int ALUOPW = 3;

  localparam logic [OPW-1:0] OP_LOAD  = 4'b0000;
  localparam logic [OPW-1:0] OP_STOP  = 4'b0001;
  localparam logic [OPW-1:0] OP_STORE = 4'b0010;
  localparam logic [OPW-1:0] OP_ADD   = 4'b0100;
  localparam logic [OPW-1:0] OP_SUB   = 4'b0110;
  localparam logic [OPW-1:0] OP_NAND  = 4'b1000;
  localparam logic [OPW-1:0] OP_ORI   = 4'b0111;
  localparam logic [OPW-1:0] OP_SHL   = 4'b1001;
  localparam logic [OPW-1:0] OP_BZ    = 4'b0101;
  localparam logic [OPW-1:0] OP_BNZ   = 4'b1101;
  localparam logic [OPW-1:0] OP_BPZ   = 4'b1011;

  localparam logic [2:0] ALUB_OPB  = 3'b000;
  localparam logic [2:0] ALUB_ONE  = 3'b001;
  localparam logic [2:0] ALUB_IMM4 = 3'b010;
  localparam logic [2:0] ALUB_IMM5 = 3'b011;
  localparam logic [2:0] ALUB_IMM3 = 3'b100;

  localparam logic [ALUOPW-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALUOPW-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALUOPW-1:0] ALU_NAND = 3'b010;
  localparam logic [ALUOPW-1:0] ALU_OR   = 3'b011;
  localparam logic [ALUOPW-1:0] ALU_SHL  = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_MEM    = 3'd4,
    S_MEMWB  = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP    = 3'd0,
    CL_ALU    = 3'd1,
    CL_MEM    = 3'd2,
    CL_BRANCH = 3'd3,
    CL_STOP   = 3'd4
  } op_class_t;

  typedef struct packed {
    logic              addr_sel;
    logic              ra_sel;
    logic              reg_in;
    logic              alu_a;
    logic [2:0]        alu_b;
    logic [ALUOPW-1:0] alu_op;
    logic              pc_write;
    logic              ir_write;
    logic              mem_read;
    logic              mem_write;
    logic              mdr_write;
    logic              rf_write;
    logic              flag_write;
    logic              halted;
  } ctrl_t;

  // Groups opcodes by the path they take out of DECODE.
  function automatic op_class_t op_class(input logic [OPW-1:0] op);
    op_class_t c;
    c = CL_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_NAND, OP_ORI, OP_SHL: c = CL_ALU;
      OP_LOAD, OP_STORE:                       c = CL_MEM;
      OP_BZ, OP_BNZ, OP_BPZ:                   c = CL_BRANCH;
      OP_STOP:                                 c = CL_STOP;
      default:                                 c = CL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map of {state, opcode, flags, mem_ready} to the datapath
// control word. Memory wait handling is compiled in with MC_MEMWAIT_EN.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           z_flag,
  input  logic           n_flag,
  input  logic           mem_ready,
  output ctrl_t          ctrl
);

  logic rdy;
  logic taken;

`ifdef MC_MEMWAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BZ:   taken = z_flag;
      OP_BNZ:  taken = ~z_flag;
      OP_BPZ:  taken = ~n_flag;
      default: taken = 1'b0;
    endcase
  end

  // One-shot strobes into PC, IR, MDR and memory are qualified by rdy so a
  // stalled access holds its selects but fires its writes only once.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = rdy;
        ctrl.alu_b    = ALUB_ONE;
        ctrl.alu_op   = ALU_ADD;
        ctrl.pc_write = rdy;
      end
      S_DECODE: begin
        ctrl.alu_b  = ALUB_IMM4;
        ctrl.alu_op = ALU_ADD;
      end
      S_EXEC: begin
        ctrl.alu_a      = 1'b1;
        ctrl.flag_write = 1'b1;
        case (opcode)
          OP_ADD:  begin ctrl.alu_b = ALUB_OPB;  ctrl.alu_op = ALU_ADD;  end
          OP_SUB:  begin ctrl.alu_b = ALUB_OPB;  ctrl.alu_op = ALU_SUB;  end
          OP_NAND: begin ctrl.alu_b = ALUB_OPB;  ctrl.alu_op = ALU_NAND; end
          OP_ORI:  begin
            ctrl.alu_b  = ALUB_IMM5;
            ctrl.alu_op = ALU_OR;
            ctrl.ra_sel = 1'b1;
          end
          OP_SHL:  begin ctrl.alu_b = ALUB_IMM3; ctrl.alu_op = ALU_SHL;  end
          default: begin ctrl.alu_b = ALUB_OPB;  ctrl.alu_op = ALU_ADD;  end
        endcase
      end
      S_WB: begin
        ctrl.rf_write = 1'b1;
        ctrl.ra_sel   = (opcode == OP_ORI);
      end
      S_MEM: begin
        ctrl.addr_sel = 1'b1;
        if (opcode == OP_LOAD) begin
          ctrl.mem_read  = 1'b1;
          ctrl.mdr_write = rdy;
        end else if (opcode == OP_STORE) begin
          ctrl.mem_write = rdy;
        end
      end
      S_MEMWB: begin
        ctrl.rf_write = 1'b1;
        ctrl.reg_in   = 1'b1;
      end
      S_BRANCH: ctrl.pc_write = taken;
      S_HALT:   ctrl.halted   = 1'b1;
      default:  ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: state register, next-state logic and reset gating
// of the decoded control word. Define MC_MEMWAIT_EN for memory wait states.
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              z_flag,
  input  logic              n_flag,
  input  logic              mem_ready,
  output logic              AddrSel,
  output logic              RASel,
  output logic              RegIn,
  output logic              ALUA,
  output logic [2:0]        ALUB,
  output logic [ALUOPW-1:0] ALUop,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MDRWrite,
  output logic              RFWrite,
  output logic              FlagWrite,
  output logic              halted,
  output logic [2:0]        state
);

  state_t state_q;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl;
  logic   rdy;

`ifdef MC_MEMWAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (rdy) state_q <= S_DECODE;
        S_DECODE: begin
          case (op_class(opcode))
            CL_ALU:    state_q <= S_EXEC;
            CL_MEM:    state_q <= S_MEM;
            CL_BRANCH: state_q <= S_BRANCH;
            CL_STOP:   state_q <= S_HALT;
            default:   state_q <= S_FETCH;
          endcase
        end
        S_EXEC:   state_q <= S_WB;
        S_WB:     state_q <= S_FETCH;
        S_MEM: begin
          if (rdy) state_q <= (opcode == OP_LOAD) ? S_MEMWB : S_FETCH;
        end
        S_MEMWB:  state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .z_flag    (z_flag),
    .n_flag    (n_flag),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_dec)
  );

  // Reset forces a quiet control word immediately, so an aborted
  // instruction cannot write anything while reset is held.
  assign ctrl = reset ? '0 : ctrl_dec;

  assign AddrSel   = ctrl.addr_sel;
  assign RASel     = ctrl.ra_sel;
  assign RegIn     = ctrl.reg_in;
  assign ALUA      = ctrl.alu_a;
  assign ALUB      = ctrl.alu_b;
  assign ALUop     = ctrl.alu_op;
  assign PCWrite   = ctrl.pc_write;
  assign IRWrite   = ctrl.ir_write;
  assign MemRead   = ctrl.mem_read;
  assign MemWrite  = ctrl.mem_write;
  assign MDRWrite  = ctrl.mdr_write;
  assign RFWrite   = ctrl.rf_write;
  assign FlagWrite = ctrl.flag_write;
  assign halted    = ctrl.halted;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected control-word sequences are
// queued from the instruction rules and compared cycle by cycle.
module tb_mc_ctrl_fsm;

  localparam logic [3:0] LOAD = 4'b0000, STOP = 4'b0001, STORE = 4'b0010;
  localparam logic [3:0] ADD = 4'b0100, SUB = 4'b0110, NAND = 4'b1000;
  localparam logic [3:0] ORI = 4'b0111, SHL = 4'b1001;
  localparam logic [3:0] BZ = 4'b0101, BNZ = 4'b1101, BPZ = 4'b1011;
  // PCWrite, IRWrite, MemWrite, MDRWrite positions in the bench word
  localparam logic [17:0] STROBES = 18'h000D8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       z_flag = 1'b0, n_flag = 1'b0, mem_ready = 1'b1;
  logic       AddrSel, RASel, RegIn, ALUA;
  logic [2:0] ALUB, ALUop;
  logic       PCWrite, IRWrite, MemRead, MemWrite, MDRWrite, RFWrite, FlagWrite, halted;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];
  logic [3:0]  op_q[$];
  logic        z_q[$], n_q[$], rdy_q[$];
  string       tag_q[$];

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z_flag(z_flag), .n_flag(n_flag),
    .mem_ready(mem_ready), .AddrSel(AddrSel), .RASel(RASel), .RegIn(RegIn),
    .ALUA(ALUA), .ALUB(ALUB), .ALUop(ALUop), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MDRWrite(MDRWrite), .RFWrite(RFWrite),
    .FlagWrite(FlagWrite), .halted(halted), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%05h exp=%05h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [17:0] obs_word();
    return {AddrSel, RASel, RegIn, ALUA, ALUB, ALUop, PCWrite, IRWrite,
            MemRead, MemWrite, MDRWrite, RFWrite, FlagWrite, halted};
  endfunction

  function automatic logic [17:0] cw(input logic a, input logic ra, input logic ri,
                                     input logic aa, input logic [2:0] ab,
                                     input logic [2:0] ao, input logic pw, input logic iw,
                                     input logic mr, input logic mw, input logic md,
                                     input logic rf, input logic fw, input logic h);
    return {a, ra, ri, aa, ab, ao, pw, iw, mr, mw, md, rf, fw, h};
  endfunction

  // reference model: what each cycle of an instruction must look like
  task automatic push_step(input string tag, input logic [17:0] w, input logic [3:0] op,
                           input logic z, input logic n, input logic rdy);
    tag_q.push_back(tag);
    exp_q.push_back(w);
    op_q.push_back(op);
    z_q.push_back(z);
    n_q.push_back(n);
    rdy_q.push_back(rdy);
  endtask

  task automatic push_any(input string tag, input logic [17:0] w, input logic [3:0] op);
    push_step(tag, w, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
  endtask

  task automatic push_mem(input string tag, input logic [17:0] w, input logic [3:0] op,
                          input int waits);
`ifdef MC_MEMWAIT_EN
    for (int i = 0; i < waits; i++)
      push_step({tag, "_wait"}, w & ~STROBES, op, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
    push_step(tag, w, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
`else
    if (waits < 0) push_any(tag, w, op);
    else push_any(tag, w, op);
`endif
  endtask

  // fz: -1 random flags, 0/1 forces z_flag in the branch cycle
  task automatic build_instr(input logic [3:0] op, input int fz, input int fetch_waits);
    logic z, n, taken, ori;
    ori = (op == ORI);
    push_mem("fetch", cw(0,0,0,0,3'b001,3'b000,1,1,1,0,0,0,0,0), op, fetch_waits);
    push_any("decode", cw(0,0,0,0,3'b010,3'b000,0,0,0,0,0,0,0,0), op);
    case (op)
      ADD, SUB, NAND, ORI, SHL: begin
        logic [2:0] ab, ao;
        case (op)
          ADD:     begin ab = 3'b000; ao = 3'b000; end
          SUB:     begin ab = 3'b000; ao = 3'b001; end
          NAND:    begin ab = 3'b000; ao = 3'b010; end
          ORI:     begin ab = 3'b011; ao = 3'b011; end
          default: begin ab = 3'b100; ao = 3'b100; end
        endcase
        push_any("exec", cw(0,ori,0,1,ab,ao,0,0,0,0,0,0,1,0), op);
        push_any("wb", cw(0,ori,0,0,3'b000,3'b000,0,0,0,0,0,1,0,0), op);
      end
      LOAD: begin
        push_mem("load_mem", cw(1,0,0,0,3'b000,3'b000,0,0,1,0,1,0,0,0), op,
                 $urandom_range(0, 3));
        push_any("load_wb", cw(0,0,1,0,3'b000,3'b000,0,0,0,0,0,1,0,0), op);
      end
      STORE: push_mem("store_mem", cw(1,0,0,0,3'b000,3'b000,0,0,0,1,0,0,0,0), op,
                      $urandom_range(0, 3));
      BZ, BNZ, BPZ: begin
        z = (fz < 0) ? 1'($urandom_range(0, 1)) : 1'(fz);
        n = 1'($urandom_range(0, 1));
        taken = (op == BZ) ? z : (op == BNZ) ? !z : !n;
        push_step("branch", cw(0,0,0,0,3'b000,3'b000,taken,0,0,0,0,0,0,0), op, z, n,
                  1'($urandom_range(0, 1)));
      end
      STOP:
        for (int i = 0; i < 20; i++)
          push_any("halt", cw(0,0,0,0,3'b000,3'b000,0,0,0,0,0,0,0,1),
                   4'($urandom_range(0, 15)));
      default: ;
    endcase
  endtask

  // driver: one cycle per queued step; inputs after posedge, sample at negedge
  task automatic run_steps(input int max_steps);
    int n_done = 0;
    while (exp_q.size() > 0 && n_done < max_steps) begin
      string       tag;
      logic [17:0] w;
      tag = tag_q.pop_front();
      w = exp_q.pop_front();
      opcode = op_q.pop_front();
      z_flag = z_q.pop_front();
      n_flag = n_q.pop_front();
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      check(tag, obs_word(), w);
      @(posedge clk);
      #1;
      n_done++;
    end
  endtask

  task automatic flush();
    tag_q.delete(); exp_q.delete(); op_q.delete();
    z_q.delete(); n_q.delete(); rdy_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    flush();
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      opcode = 4'($urandom_range(0, 15));
      z_flag = 1'($urandom_range(0, 1));
      n_flag = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset", obs_word(), 18'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    @(posedge clk);
    #1;
    do_reset(3);

    // directed: test-plan instructions
    build_instr(ADD, -1, 0);   run_steps(1000);
    build_instr(LOAD, -1, 0);  run_steps(1000);
    build_instr(BZ, 1, 0);     run_steps(1000);
    build_instr(BZ, 0, 0);     run_steps(1000);
    build_instr(BNZ, 0, 0);    run_steps(1000);
    build_instr(BNZ, 1, 0);    run_steps(1000);
    build_instr(ORI, -1, 0);   run_steps(1000);
    build_instr(STORE, -1, 0); run_steps(1000);
    build_instr(4'b0011, -1, 0); run_steps(1000);

    // random instruction stream (everything but STOP)
    for (int i = 0; i < 80; i++) begin
      do op = 4'($urandom_range(0, 15)); while (op == STOP);
      build_instr(op, -1, $urandom_range(0, 3));
      run_steps(1000);
    end

    // reset mid-instruction, then a clean instruction from FETCH
    build_instr(ADD, -1, 0);  run_steps(2); do_reset(1);
    build_instr(SUB, -1, 0);  run_steps(1000);
    build_instr(LOAD, -1, 0); run_steps(3); do_reset(2);
    build_instr(SHL, -1, 0);  run_steps(1000);

`ifdef MC_MEMWAIT_EN
    // fetch stalled four cycles; strobes must fire once on the ready cycle
    build_instr(ADD, -1, 4);  run_steps(1000);
    // reset during a fetch wait
    build_instr(NAND, -1, 3); run_steps(2); do_reset(1);
    build_instr(STORE, -1, 0); run_steps(1000);
`endif

    // STOP: halted for 20 cycles with no enables, then reset recovers
    build_instr(STOP, -1, 0); run_steps(1000);
    do_reset(2);
    build_instr(ADD, -1, 0);  run_steps(1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
